// File: rtl/fft_bitrev_sink.sv
// fft_bitrev_sink: reorders a bit-reversed FFT output frame into natural order.
// Two ping-pong banks: the write side fills one bank at bit-reversed addresses
// while the read side drains the other sequentially. Each bank carries a full
// flag; a bank is only written while not full and only read while full, so the
// two sides never touch the same bank in the same cycle.
module fft_bitrev_sink #(
  parameter int N_LOG2 = 9,
  parameter int DW     = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          over,
  input  logic [DW-1:0] data_in_real,
  input  logic [DW-1:0] data_in_img,
  output logic [DW-1:0] data_out_real,
  output logic [DW-1:0] data_out_img,
  output logic          out_valid,
  output logic          out_first,
  output logic          out_last,
  output logic          frame_err
);

  localparam int N = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] LAST = N_LOG2'(N - 1);

  typedef enum logic {IDLE, FILL}   wstate_t;
  typedef enum logic {RIDLE, DRAIN} rstate_t;

  // Bank select is the MSB of the address: {bank, index}.
  logic [2*DW-1:0] mem [2*N];
  logic [1:0]      full;

  wstate_t         wstate;
  logic [N_LOG2-1:0] wcnt;
  logic            wbank;

  rstate_t         rstate;
  logic [N_LOG2-1:0] rcnt;
  logic            rbank;

  // Write-side decode
  logic              start_ok;
  logic              wr_en;
  logic              wr_done;
  logic [N_LOG2-1:0] wr_idx;
  logic [N_LOG2-1:0] wr_rev;

  // A start can only open a bank the reader has already released.
  assign start_ok = start && !full[wbank];

  // Decide whether this cycle's sample is stored, and at which natural index.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = '0;
    wr_done = 1'b0;
    if (start_ok) begin
      // New frame or restart: sample 0 always lands at index 0.
      wr_en = 1'b1;
    end else if (wstate == FILL && !start) begin
      if (over) begin
        // Only a correctly placed over completes the frame.
        wr_en   = (wcnt == LAST);
        wr_idx  = wcnt;
        wr_done = (wcnt == LAST);
      end else if (wcnt != LAST) begin
        wr_en  = 1'b1;
        wr_idx = wcnt;
      end
    end
  end

  // Bit reversal of the write index is pure wiring.
  for (genvar i = 0; i < N_LOG2; i++) begin : g_rev
    assign wr_rev[i] = wr_idx[N_LOG2-1-i];
  end

  // Sample storage; contents need no reset because the full flags gate reads.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wbank, wr_rev}] <= {data_in_real, data_in_img};
  end

  // Write FSM: frame tracking, bank toggling and frame_err pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wstate    <= IDLE;
      wcnt      <= '0;
      wbank     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (wstate)
        IDLE: begin
          if (start) begin
            if (start_ok) begin
              wcnt   <= N_LOG2'(1);
              wstate <= FILL;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        FILL: begin
          if (start) begin
            // Partial frame is abandoned; restart in the same bank.
            frame_err <= 1'b1;
            if (start_ok) begin
              wcnt <= N_LOG2'(1);
            end else begin
              wcnt   <= '0;
              wstate <= IDLE;
            end
          end else if (over) begin
            wcnt   <= '0;
            wstate <= IDLE;
            if (wcnt == LAST) wbank     <= ~wbank;
            else              frame_err <= 1'b1;
          end else if (wcnt == LAST) begin
            // Frame is as long as it may be but over never came.
            wcnt      <= '0;
            wstate    <= IDLE;
            frame_err <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        default: begin
          wcnt   <= '0;
          wstate <= IDLE;
        end
      endcase
    end
  end

  // Read-side decode
  logic            rd_issue;
  logic            rd_done;
  logic [2*DW-1:0] rd_word;

  // In RIDLE rcnt sits at 0, so a newly full bank is addressed at index 0
  // the very cycle it is seen.
  assign rd_issue = (rstate == DRAIN) || full[rbank];
  assign rd_done  = rd_issue && (rcnt == LAST);
  assign rd_word  = mem[{rbank, rcnt}];

  // Read FSM with registered memory output; flags stay aligned with data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rstate        <= RIDLE;
      rcnt          <= '0;
      rbank         <= 1'b0;
      data_out_real <= '0;
      data_out_img  <= '0;
      out_valid     <= 1'b0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
    end else if (rd_issue) begin
      {data_out_real, data_out_img} <= rd_word;
      out_valid <= 1'b1;
      out_first <= (rcnt == '0);
      out_last  <= (rcnt == LAST);
      rcnt      <= rcnt + 1'b1;
      if (rcnt == LAST) begin
        rbank  <= ~rbank;
        rstate <= full[~rbank] ? DRAIN : RIDLE;
      end else begin
        rstate <= DRAIN;
      end
    end else begin
      rstate        <= RIDLE;
      rcnt          <= '0;
      data_out_real <= '0;
      data_out_img  <= '0;
      out_valid     <= 1'b0;
      out_first     <= 1'b0;
      out_last      <= 1'b0;
    end
  end

  // Full flags: set by a completed write, cleared after the last read.
  always_ff @(posedge clk) begin
    if (rst) begin
      full <= '0;
    end else begin
      if (wr_done) full[wbank] <= 1'b1;
      if (rd_done) full[rbank] <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_bitrev_sink.sv
// Directed bench for fft_bitrev_sink: a 512-point instance for framing,
// latency, error and reset cases, plus an 8-point instance for a literal
// reorder table.
module tb_fft_bitrev_sink;
  localparam int NL  = 9;
  localparam int N   = 512;
  localparam int DW  = 32;
  localparam int DW3 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, over = 1'b0;
  logic [DW-1:0] din_re = '0, din_im = '0;
  logic [DW-1:0] dout_re, dout_im;
  logic ov, of, ol, ferr;

  logic start3 = 1'b0, over3 = 1'b0;
  logic [DW3-1:0] din3_re = '0, din3_im = '0;
  logic [DW3-1:0] dout3_re, dout3_im;
  logic ov3, of3, ol3, ferr3;

  fft_bitrev_sink #(.N_LOG2(NL), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .over(over),
    .data_in_real(din_re), .data_in_img(din_im),
    .data_out_real(dout_re), .data_out_img(dout_im),
    .out_valid(ov), .out_first(of), .out_last(ol), .frame_err(ferr)
  );

  fft_bitrev_sink #(.N_LOG2(3), .DW(DW3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .over(over3),
    .data_in_real(din3_re), .data_in_img(din3_im),
    .data_out_real(dout3_re), .data_out_img(dout3_im),
    .out_valid(ov3), .out_first(of3), .out_last(ol3), .frame_err(ferr3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] re;
    logic [31:0] im;
    logic        first;
    logic        last;
  } rec_t;

  rec_t q[$];
  rec_t q3[$];
  int   errq[$];
  int   errq3[$];
  int   zviol = 0;

  // Record every output beat and every error pulse; flag nonzero idle outputs.
  always @(negedge clk) begin
    if (ov) q.push_back('{cyc, dout_re, dout_im, of, ol});
    else if (dout_re != 0 || dout_im != 0 || of || ol) zviol <= zviol + 1;
    if (ferr) errq.push_back(cyc);
    if (ov3) q3.push_back('{cyc, 32'(dout3_re), 32'(dout3_im), of3, ol3});
    else if (dout3_re != 0 || dout3_im != 0 || of3 || ol3) zviol <= zviol + 1;
    if (ferr3) errq3.push_back(cyc);
  end

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r |= (1 << (w - 1 - i));
    return r;
  endfunction

  function automatic logic [31:0] exp_re(input int fid, input int k);
    return 32'(fid * 65536 + k);
  endfunction

  function automatic logic [31:0] exp_im(input int fid, input int k);
    return 32'hA500_0000 | 32'(fid << 12) | 32'(k);
  endfunction

  // Drive n stream positions of frame fid; start at position 0, over at over_at.
  task automatic stream(input int fid, input int n, input int over_at,
                        output int t_first, output int t_over);
    t_first = -1;
    t_over  = -1;
    for (int p = 0; p < n; p++) begin
      @(posedge clk); #1;
      start  = (p == 0);
      over   = (p == over_at);
      din_re = exp_re(fid, brev(p, NL));
      din_im = exp_im(fid, brev(p, NL));
      if (p == 0) t_first = cyc;
      if (p == over_at) t_over = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0; over = 1'b0; din_re = '0; din_im = '0;
    end
  endtask

  // Pop one expected 512-beat frame and compare it beat by beat.
  task automatic check_frame(input string tag, input int fid, input int c0);
    int   bad = 0;
    rec_t r;
    chk({tag, "_avail"}, 64'(q.size() >= N), 64'd1);
    if (q.size() < N) return;
    chk({tag, "_first_cyc"}, 64'(q[0].cyc), 64'(c0));
    chk({tag, "_last_cyc"}, 64'(q[N-1].cyc), 64'(c0 + N - 1));
    chk({tag, "_last_flag"}, 64'(q[N-1].last), 64'd1);
    for (int k = 0; k < N; k++) begin
      r = q.pop_front();
      if (r.cyc != c0 + k || r.re !== exp_re(fid, k) || r.im !== exp_im(fid, k) ||
          r.first !== (k == 0) || r.last !== (k == N - 1)) bad++;
    end
    chk({tag, "_bad_beats"}, 64'(bad), 64'd0);
  endtask

  initial begin
    int ts, to, t2, t3, t4, t6, t8s, t8, t9, rcy, t3o;
    int in3[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    rec_t r;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_flags", 64'({of, ol, ferr}), 64'd0);
    chk("rst_data", {dout_re, dout_im}, 64'd0);
    chk("rst_valid3", 64'(ov3), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // Single frame: latency T+2 .. T+513
    q.delete(); errq.delete();
    stream(1, N, N - 1, ts, to);
    idle(520);
    check_frame("s1", 1, to + 2);
    chk("s1_err", 64'(errq.size()), 64'd0);
    chk("s1_extra", 64'(q.size()), 64'd0);

    // Three back-to-back frames
    q.delete(); errq.delete();
    stream(2, N, N - 1, ts, t2);
    stream(3, N, N - 1, ts, t3);
    stream(4, N, N - 1, ts, t4);
    idle(530);
    check_frame("s2a", 2, t2 + 2);
    check_frame("s2b", 3, t3 + 2);
    check_frame("s2c", 4, t4 + 2);
    chk("s2_err", 64'(errq.size()), 64'd0);
    chk("s2_extra", 64'(q.size()), 64'd0);

    // Early over at wcnt = 300, then a good frame
    q.delete(); errq.delete();
    stream(5, 301, 300, ts, to);
    idle(5);
    stream(6, N, N - 1, ts, t6);
    idle(520);
    chk("s3_err_cnt", 64'(errq.size()), 64'd1);
    if (errq.size() > 0) chk("s3_err_cyc", 64'(errq[0]), 64'(to + 1));
    check_frame("s3", 6, t6 + 2);
    chk("s3_extra", 64'(q.size()), 64'd0);

    // Restart at wcnt = 100
    q.delete(); errq.delete();
    stream(7, 100, -1, ts, to);
    stream(8, N, N - 1, t8s, t8);
    idle(520);
    chk("s4_err_cnt", 64'(errq.size()), 64'd1);
    if (errq.size() > 0) chk("s4_err_cyc", 64'(errq[0]), 64'(t8s + 1));
    check_frame("s4", 8, t8 + 2);
    chk("s4_extra", 64'(q.size()), 64'd0);

    // Reset at wcnt = 200 of frame 10 while frame 9 drains
    q.delete(); errq.delete();
    stream(9, N, N - 1, ts, t9);
    stream(10, 200, -1, ts, to);
    @(posedge clk); #1;
    start = 1'b0; over = 1'b0; rst = 1'b1;
    rcy = cyc;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_valid", 64'({ov, of, ol}), 64'd0);
    chk("s5_data", {dout_re, dout_im}, 64'd0);
    #1;
    chk("s5_beats", 64'(q.size()), 64'd200);
    if (q.size() > 0) begin
      r = q[q.size() - 1];
      chk("s5_last_cyc", 64'(r.cyc), 64'(rcy));
      chk("s5_last_re", 64'(r.re), 64'(exp_re(9, q.size() - 1)));
    end
    idle(600);
    chk("s5_silent", 64'(q.size()), 64'd200);
    chk("s5_err", 64'(errq.size()), 64'd0);
    q.delete();
    stream(11, N, N - 1, ts, to);
    idle(520);
    check_frame("s5", 11, to + 2);
    chk("s5_extra", 64'(q.size()), 64'd0);

    // 8-point build: literal reorder table
    q3.delete(); errq3.delete();
    for (int p = 0; p < 8; p++) begin
      @(posedge clk); #1;
      start3  = (p == 0);
      over3   = (p == 7);
      din3_re = 16'(in3[p]);
      din3_im = 16'(in3[p] + 16'h50);
      if (p == 7) t3o = cyc;
    end
    @(posedge clk); #1;
    start3 = 1'b0; over3 = 1'b0; din3_re = '0; din3_im = '0;
    idle(12);
    chk("s6_beats", 64'(q3.size()), 64'd8);
    chk("s6_err", 64'(errq3.size()), 64'd0);
    for (int k = 0; k < 8 && k < q3.size(); k++) begin
      chk($sformatf("s6_re%0d", k), 64'(q3[k].re), 64'(k));
      chk($sformatf("s6_im%0d", k), 64'(q3[k].im), 64'(k + 16'h50));
      chk($sformatf("s6_cyc%0d", k), 64'(q3[k].cyc), 64'(t3o + 2 + k));
      chk($sformatf("s6_fl%0d", k), 64'({q3[k].first, q3[k].last}),
          64'({k == 0, k == 7}));
    end

    chk("zero_when_idle", 64'(zviol), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
